// File: rtl/sigmoid_seq.sv
// sigmoid_seq: sequencer that owns the sigmoid lookup block.
//   After reset or a reload request it streams N_ENTRIES table words into the
//   sigmoid table. It then accepts 8.8 MAC results, issues a one-cycle evaluate
//   request, waits SIG_LAT cycles, captures the result and offers it downstream.
//
// Optional feature: define SIGMOID_SEQ_SAT_BYPASS_EN to skip the sigmoid block
//   for inputs below -6.0 (result 0x0000) or above +6.0 (result 0x0100).
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   load_start                  request a table reload (honoured in LOAD/IDLE only)
//   cfg_valid/cfg_ready/cfg_data table word stream, address order 0..N_ENTRIES-1
//   lut_loaded                  table completely written since last reset/reload
//   in_valid/in_ready/in_data   signed 8.8 MAC result
//   out_valid/out_ready/out_data 8.8 sigmoid result
//   sig_we/sig_addr/sig_d       table write port to the sigmoid block
//   sig_done/sig_in             evaluate request to the sigmoid block
//   sig_out                     sigmoid block result
//   busy                        sequencer is not idle
module sigmoid_seq #(
  parameter int unsigned N_ENTRIES = 121,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned SIG_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [15:0]       cfg_data,
  output logic              lut_loaded,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic              sig_we,
  output logic [ADDR_W-1:0] sig_addr,
  output logic [15:0]       sig_d,
  output logic              sig_done,
  output logic [15:0]       sig_in,
  input  logic [15:0]       sig_out,
  output logic              busy
);

  localparam int unsigned WaitW = (SIG_LAT > 1) ? $clog2(SIG_LAT) : 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_ENTRIES - 1);
  localparam logic [WaitW-1:0]  LastWait = WaitW'(SIG_LAT - 1);

  typedef enum logic [2:0] {StLoad, StIdle, StEval, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              lut_loaded_q, lut_loaded_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       sig_in_q, sig_in_d;
  logic [15:0]       out_data_q, out_data_d;

  logic              cfg_acc, in_acc;
  logic              sat_lo, sat_hi;
  logic [ADDR_W-1:0] load_addr;

`ifdef SIGMOID_SEQ_SAT_BYPASS_EN
  assign sat_lo = $signed(in_data) < $signed(16'hFA00);
  assign sat_hi = $signed(in_data) > $signed(16'h0600);
`else
  assign sat_lo = 1'b0;
  assign sat_hi = 1'b0;
`endif

  // Handshake outputs decode the state; reset forces every output low.
  assign cfg_ready  = !reset && (state_q == StLoad);
  assign in_ready   = !reset && (state_q == StIdle) && lut_loaded_q && !load_start;
  assign out_valid  = !reset && (state_q == StHold);
  assign sig_done   = !reset && (state_q == StEval);
  assign busy       = !reset && (state_q != StIdle);

  assign lut_loaded = lut_loaded_q;
  assign sig_we     = we_q;
  assign sig_addr   = waddr_q;
  assign sig_d      = wdata_q;
  assign sig_in     = sig_in_q;
  assign out_data   = out_data_q;

  assign cfg_acc = cfg_valid && cfg_ready;
  assign in_acc  = in_valid && in_ready;

  // A restart request in LOAD rewinds to address 0; a word accepted in that
  // same cycle becomes the first word of the new pass.
  assign load_addr = load_start ? '0 : cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    lut_loaded_d = lut_loaded_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    sig_in_d     = sig_in_q;
    out_data_d   = out_data_q;

    unique case (state_q)
      StLoad: begin
        if (cfg_acc) begin
          we_d    = 1'b1;
          waddr_d = load_addr;
          wdata_d = cfg_data;
          if (load_addr == LastAddr) begin
            state_d      = StIdle;
            lut_loaded_d = 1'b1;
            cnt_d        = '0;
          end else begin
            cnt_d = load_addr + 1'b1;
          end
        end else if (load_start) begin
          cnt_d = '0;
        end
      end
      StIdle: begin
        if (load_start) begin
          state_d      = StLoad;
          lut_loaded_d = 1'b0;
          cnt_d        = '0;
        end else if (in_acc) begin
          if (sat_lo) begin
            out_data_d = 16'h0000;
            state_d    = StHold;
          end else if (sat_hi) begin
            out_data_d = 16'h0100;
            state_d    = StHold;
          end else begin
            sig_in_d = in_data;
            state_d  = StEval;
          end
        end
      end
      StEval: begin
        wait_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (wait_q == LastWait) begin
          out_data_d = sig_out;
          state_d    = StHold;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StLoad;
      cnt_q        <= '0;
      wait_q       <= '0;
      lut_loaded_q <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      sig_in_q     <= '0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wait_q       <= wait_d;
      lut_loaded_q <= lut_loaded_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      sig_in_q     <= sig_in_d;
      out_data_q   <= out_data_d;
    end
  end

endmodule

// File: tb/tb_sigmoid_seq.sv
// Scoreboard bench for sigmoid_seq with a stand-in sigmoid block.
module tb_sigmoid_seq;

  localparam int unsigned N   = 121;
  localparam int unsigned AW  = 7;
  localparam int unsigned LAT = 1;

  logic          clk = 1'b0;
  logic          reset, load_start;
  logic          cfg_valid, cfg_ready;
  logic [15:0]   cfg_data;
  logic          lut_loaded;
  logic          in_valid, in_ready;
  logic [15:0]   in_data;
  logic          out_valid, out_ready;
  logic [15:0]   out_data;
  logic          sig_we;
  logic [AW-1:0] sig_addr;
  logic [15:0]   sig_d;
  logic          sig_done;
  logic [15:0]   sig_in;
  logic [15:0]   sig_out;
  logic          busy;

  sigmoid_seq #(.N_ENTRIES(N), .ADDR_W(AW), .SIG_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .lut_loaded (lut_loaded),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sig_we     (sig_we),
    .sig_addr   (sig_addr),
    .sig_d      (sig_d),
    .sig_done   (sig_done),
    .sig_in     (sig_in),
    .sig_out    (sig_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [15:0] data; int cyc; } ev_t;
  typedef struct { logic [AW-1:0] addr; logic [15:0] data; int cyc; } wr_t;

  ev_t out_q[$];
  ev_t done_q[$];
  wr_t wr_q[$];

  // Stand-in sigmoid transfer function.
  function automatic logic [15:0] sig_model(input logic [15:0] x);
    return x + 16'h0010;
  endfunction

  function automatic bit bypass(input logic [15:0] x, output logic [15:0] y);
    bit en;
    int v;
`ifdef SIGMOID_SEQ_SAT_BYPASS_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    v = int'($signed(x));
    y = 16'h0000;
    if (en && v < -1536) return 1'b1;
    if (en && v > 1536) begin
      y = 16'h0100;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Sigmoid block: result valid only SIG_LAT(=1) cycle after sig_done, junk otherwise.
  logic        done_n;
  logic [15:0] in_n;
  always @(negedge clk) begin
    done_n <= sig_done;
    in_n   <= sig_in;
  end
  always @(posedge clk) begin
    #1;
    sig_out = done_n ? sig_model(in_n) : 16'($urandom);
  end

  logic rand_ready, or_force, rnd_bit;
  always @(negedge clk) rnd_bit = ($urandom_range(0, 3) != 0);
  assign out_ready = rand_ready ? rnd_bit : or_force;

  // Monitor
  logic        ov_prev = 1'b0;
  logic        or_prev = 1'b0;
  logic [15:0] od_prev = 16'h0;
  wr_t         w_tmp;
  ev_t         e_tmp;

  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      check("we_done_excl", 32'(sig_we & sig_done), 0);
      if (sig_we) begin
        check("write_expected", 32'(wr_q.size() > 0), 1);
        if (wr_q.size() > 0) begin
          w_tmp = wr_q.pop_front();
          check("wr_addr", 32'(sig_addr), 32'(w_tmp.addr));
          check("wr_data", 32'(sig_d), 32'(w_tmp.data));
          check("wr_cycle", cyc, w_tmp.cyc);
        end
      end
      if (sig_done) begin
        check("done_expected", 32'(done_q.size() > 0), 1);
        if (done_q.size() > 0) begin
          e_tmp = done_q.pop_front();
          check("sig_in", 32'(sig_in), 32'(e_tmp.data));
          check("done_cycle", cyc, e_tmp.cyc);
        end
      end
      if (ov_prev && !or_prev) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(od_prev));
      end
      if (out_valid && !ov_prev) begin
        check("out_expected", 32'(out_q.size() > 0), 1);
        if (out_q.size() > 0) check("out_rise_cycle", cyc, out_q[0].cyc);
      end
      if (out_valid && out_ready && out_q.size() > 0) begin
        e_tmp = out_q.pop_front();
        check("out_data", 32'(out_data), 32'(e_tmp.data));
      end
    end
    ov_prev = out_valid && !reset;
    or_prev = out_ready;
    od_prev = out_data;
  end

  task automatic check_zero(input string tag);
    check({tag, "_sig_we"}, 32'(sig_we), 0);
    check({tag, "_sig_addr"}, 32'(sig_addr), 0);
    check({tag, "_sig_d"}, 32'(sig_d), 0);
    check({tag, "_sig_done"}, 32'(sig_done), 0);
    check({tag, "_sig_in"}, 32'(sig_in), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_lut_loaded"}, 32'(lut_loaded), 0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic load_words(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = 16'($urandom);
      #1;
      t = 0;
      while (!cfg_ready && t < 50) begin
        @(negedge clk);
        #1;
        t++;
      end
      check("cfg_ready", 32'(cfg_ready), 1);
      check("lut_loaded_during", 32'(lut_loaded), 0);
      wr_q.push_back('{AW'(i), cfg_data, cyc + 1});
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] x);
    int n;
    logic [15:0] y;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    #1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("send_accepted", 32'(in_ready), 1);
    if (in_ready) begin
      if (bypass(x, y)) begin
        out_q.push_back('{y, cyc + 1});
      end else begin
        done_q.push_back('{x, cyc + 1});
        out_q.push_back('{sig_model(x), cyc + 2 + int'(LAT)});
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    #1;
    while ((out_q.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("drain", out_q.size(), 0);
  endtask

  logic [15:0] x;
  int          tb;

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = 16'h0;
    in_valid   = 1'b0;
    in_data    = 16'h0;
    rand_ready = 1'b0;
    or_force   = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_zero("por");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_cfg_ready", 32'(cfg_ready), 1);
    check("post_rst_busy", 32'(busy), 1);
    check("post_rst_in_ready", 32'(in_ready), 0);

    // Partial load, restart, then a full pass.
    load_words(10);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    load_words(N);
    #1;
    check("loaded", 32'(lut_loaded), 1);
    check("loaded_idle", 32'(busy), 0);
    check("loaded_cfg_ready", 32'(cfg_ready), 0);

    send(16'h0080);
    wait_idle();

    // Backpressure in HOLD; a reload request there must be ignored.
    or_force = 1'b0;
    send(16'h0123);
    tb = 0;
    #1;
    while (!out_valid && tb < 20) begin
      @(negedge clk);
      #1;
      tb++;
    end
    check("bp_valid_seen", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      in_data    = 16'h0200;
      load_start = (i == 0);
      #1;
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_valid", 32'(out_valid), 1);
    end
    @(negedge clk);
    in_valid   = 1'b0;
    load_start = 1'b0;
    or_force   = 1'b1;
    #1;
    check("bp_release_valid", 32'(out_valid), 1);
    @(negedge clk);
    #1;
    check("bp_back_idle", 32'(busy), 0);
    check("bp_still_loaded", 32'(lut_loaded), 1);
    check("bp_in_ready_after", 32'(in_ready), 1);
    send(16'h0200);
    wait_idle();

    // Reload request beats a same-cycle input.
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = 16'h0055;
    load_start = 1'b1;
    #1;
    check("prio_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    in_valid   = 1'b0;
    load_start = 1'b0;
    #1;
    check("prio_lut_loaded", 32'(lut_loaded), 0);
    check("prio_cfg_ready", 32'(cfg_ready), 1);
    check("prio_busy", 32'(busy), 1);
    load_words(N);
    #1;
    check("reloaded", 32'(lut_loaded), 1);

    // Randomized traffic with random downstream backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: x = 16'($urandom);
        1: x = 16'h05FF + 16'($urandom_range(0, 2));
        2: x = 16'hF9FF + 16'($urandom_range(0, 2));
        default: x = 16'($urandom_range(0, 16'h0FFF)) - 16'h0800;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(x);
    end
    wait_idle();
    rand_ready = 1'b0;

    // Saturation boundaries.
    send(16'hF800);
    send(16'h0700);
    send(16'h0600);
    send(16'hFA00);
    wait_idle();

    // Reset while waiting on the sigmoid block drops the result.
    send(16'h0040);
    @(negedge clk);
    reset = 1'b1;
    out_q.delete();
    done_q.delete();
    wr_q.delete();
    repeat (3) begin
      @(negedge clk);
      #1;
      check_zero("rst_wait");
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wait_cfg_ready", 32'(cfg_ready), 1);
    check("rst_wait_lut_loaded", 32'(lut_loaded), 0);
    check("rst_wait_out_valid", 32'(out_valid), 0);
    repeat (4) @(negedge clk);
    load_words(N);
    send(16'h0100);
    wait_idle();

    check("done_q_empty", done_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
